// File: rtl/arm_exec_core.sv
// arm_exec_core: execute-core slice of a 5-stage ARM pipeline.
// 16 x 32-bit register file (two combinational read ports, one synchronous
// write port) plus a stateless 32-bit ALU (ADD/SUB/AND/ORR) with NZCV flags.
// Optional feature macro: REGFILE_BYPASS_EN (write-through on the read ports).
module arm_exec_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            alu_control,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            alu_flags
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
  localparam int unsigned MSB      = DATA_WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ORR = 2'b11;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Register array: async clear on rst (drops any coincident write), else write on clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_addr] <= write_data;
    end
  end

  // Read port 1: stored value, optional write-through, forced to zero during reset
  always_comb begin
    read_data1 = regs_q[read_addr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (read_addr1 == write_addr)) begin
      read_data1 = write_data;
    end
`endif
    if (rst) begin
      read_data1 = '0;
    end
  end

  // Read port 2: same behaviour as port 1
  always_comb begin
    read_data2 = regs_q[read_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (read_addr2 == write_addr)) begin
      read_data2 = write_data;
    end
`endif
    if (rst) begin
      read_data2 = '0;
    end
  end

  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH:0]   sum;
  logic                  carry_in;
  logic                  flag_c;
  logic                  flag_v;

  // ALU: ADD and SUB share one adder; SUB is a + ~b + 1 so carry-out means "no borrow"
  always_comb begin
    op_b     = b;
    carry_in = 1'b0;
    if (alu_control == OP_SUB) begin
      op_b     = ~b;
      carry_in = 1'b1;
    end
    sum = {1'b0, a} + {1'b0, op_b} + {{DATA_WIDTH{1'b0}}, carry_in};

    result = sum[DATA_WIDTH-1:0];
    flag_c = sum[DATA_WIDTH];
    // Overflow: operands into the adder share a sign that the sum does not
    flag_v = (a[MSB] == op_b[MSB]) && (sum[MSB] != a[MSB]);
    case (alu_control)
      OP_AND: begin
        result = a & b;
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
      OP_ORR: begin
        result = a | b;
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
      default: ;
    endcase
    alu_flags = {result[MSB], (result == '0), flag_c, flag_v};
  end

endmodule

// File: tb/tb_arm_exec_core.sv
// Self-checking bench for arm_exec_core: directed cases plus randomized
// register-file traffic and ALU operations checked against a behavioural model.
module tb_arm_exec_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  read_addr1 = '0;
  logic [3:0]  read_addr2 = '0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  alu_control = 2'b00;
  logic [31:0] result;
  logic [3:0]  alu_flags;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] mem [16];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  arm_exec_core #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .write_addr(write_addr),
    .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2), .a(a), .b(b),
    .alu_control(alu_control), .result(result), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    if (rst) return 32'h0;
    if (BYPASS && wr_en && addr == write_addr) return write_data;
    return mem[addr];
  endfunction

  // Reference ALU computed with wide integer arithmetic
  function automatic void model_alu(input logic [1:0] op, input logic [31:0] x,
                                    input logic [31:0] y, output logic [31:0] r,
                                    output logic [3:0] f);
    longint unsigned ux = {32'h0, x};
    longint unsigned uy = {32'h0, y};
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint sres;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      2'b00: begin
        r = 32'(ux + uy);
        c = (ux + uy) > 64'hFFFF_FFFF;
        sres = sx + sy;
        v = (sres > SMAX) || (sres < SMIN);
      end
      2'b01: begin
        r = 32'(ux - uy);
        c = (ux >= uy);
        sres = sx - sy;
        v = (sres > SMAX) || (sres < SMIN);
      end
      2'b10: r = x & y;
      default: r = x | y;
    endcase
    f = {r[31], r == 32'h0, c, v};
  endfunction

  task automatic alu_test(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [3:0]  ef;
    alu_control = op; a = x; b = y;
    #1;
    model_alu(op, x, y, er, ef);
    check("alu_result", result, er);
    check("alu_flags", {28'h0, alu_flags}, {28'h0, ef});
  endtask

  task automatic alu_directed(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] er, input logic [3:0] ef);
    alu_control = op; a = x; b = y;
    #1;
    check("alu_dir_result", result, er);
    check("alu_dir_flags", {28'h0, alu_flags}, {28'h0, ef});
  endtask

  // One register-file cycle: drive at negedge, check before and after the write edge
  task automatic step(input logic wen, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] ra1, input logic [3:0] ra2);
    @(negedge clk);
    wr_en = wen; write_addr = wa; write_data = wd;
    read_addr1 = ra1; read_addr2 = ra2;
    #1;
    check("rd1_pre", read_data1, model_read(ra1));
    check("rd2_pre", read_data2, model_read(ra2));
    @(posedge clk);
    if (wen && !rst) mem[wa] = wd;
    #1;
    wr_en = 1'b0;
    #1;
    check("rd1_post", read_data1, model_read(ra1));
    check("rd2_post", read_data2, model_read(ra2));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #1;
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset held: every address reads zero on both ports
    #2;
    for (int i = 0; i < 16; i++) begin
      read_addr1 = 4'(i);
      read_addr2 = 4'(15 - i);
      #1;
      check("reset_rd1", read_data1, 32'h0);
      check("reset_rd2", read_data2, 32'h0);
    end
    alu_directed(2'b00, 32'h0, 32'h0, 32'h0, 4'b0100);
    @(negedge clk);
    rst = 1'b0;

    // Basic writes and a disabled write
    step(1'b1, 4'd5,  32'hDEADBEEF, 4'd5, 4'd15);
    step(1'b1, 4'd15, 32'h00000008, 4'd5, 4'd15);
    step(1'b0, 4'd5,  32'hFFFFFFFF, 4'd5, 4'd15);
    read_addr1 = 4'd5; read_addr2 = 4'd5; #1;
    check("r5_p1", read_data1, 32'hDEADBEEF);
    check("r5_p2", read_data2, 32'hDEADBEEF);
    read_addr1 = 4'd15; read_addr2 = 4'd15; #1;
    check("r15_p1", read_data1, 32'h00000008);
    check("r15_p2", read_data2, 32'h00000008);

    // Same-cycle write/read of R2
    step(1'b1, 4'd2, 32'h1, 4'd2, 4'd2);
    @(negedge clk);
    wr_en = 1'b1; write_addr = 4'd2; write_data = 32'h2;
    read_addr1 = 4'd2; read_addr2 = 4'd2;
    #1;
    check("r2_same_cycle", read_data1, BYPASS ? 32'h2 : 32'h1);
    @(posedge clk);
    mem[2] = 32'h2;
    #1;
    wr_en = 1'b0;
    #1;
    check("r2_after_edge", read_data1, 32'h2);

    // Async reset mid-run clears R3 without an edge; a coincident write is dropped
    step(1'b1, 4'd3, 32'h12345678, 4'd3, 4'd3);
    @(negedge clk);
    read_addr1 = 4'd3; read_addr2 = 4'd4;
    wr_en = 1'b1; write_addr = 4'd4; write_data = 32'hCAFEF00D;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #1;
    check("rst_async_r3", read_data1, 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rst_drop_r4", read_data2, 32'h0);
    check("rst_keep_r3", read_data1, 32'h0);

    // Directed ALU boundary cases
    alu_directed(2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
    alu_directed(2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
    alu_directed(2'b01, 32'd5, 32'd5, 32'h00000000, 4'b0110);
    alu_directed(2'b01, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000);
    alu_directed(2'b01, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011);
    alu_directed(2'b10, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100);
    alu_directed(2'b11, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b1000);

    // Randomized register-file traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end

    // Randomized ALU, biased toward sign/carry boundaries
    for (int n = 0; n < 300; n++) begin
      logic [31:0] x, y;
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 3))
        0: x = {x[31], 31'h7FFFFFFF};
        1: y = x;
        2: y = ~x;
        default: ;
      endcase
      alu_test(2'($urandom_range(0, 3)), x, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
